// File: rtl/aes_key_expand_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_expand_pkg
// Description : Shared AES constants: S-box table, round constants, NR.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_key_expand_pkg;

    localparam logic [3:0] c_nr = 4'd10;

    // Row-major S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] c_sbox = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [10:1][7:0] c_rcon = {
        8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
        8'h10, 8'h08, 8'h04, 8'h02, 8'h01
    };

    function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
        logic [7:0] idx;
        idx = 8'hff - b;
        return c_sbox[{idx, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon_lookup(input logic [3:0] r);
        logic [7:0] v;
        v = 8'h00;
        if (r >= 4'd1 && r <= c_nr) begin
            v = c_rcon[r];
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
// Module      : aes_sbox
// Description : Combinational AES S-box byte substitution.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_sbox
    import aes_key_expand_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    assign o_byte = sbox_lookup(i_byte);

endmodule
`default_nettype wire

// File: rtl/aes_key_expand.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_expand
// Description : Iterative AES-128 key schedule streaming round keys 0..10.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_expand
    import aes_key_expand_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    input  logic [127:0] key,
    output logic         key_ready,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk,
    output logic [3:0]   rk_round,
    output logic         rk_last
);

    localparam logic [0:0] c_st_idle   = 1'b0;
    localparam logic [0:0] c_st_stream = 1'b1;

    logic [0:0]   r_state;
    logic         r_key_ready;
    logic         r_rk_valid;
    logic [127:0] r_rk;
    logic [3:0]   r_round;

    logic [3:0]   w_round_inc;
    logic [31:0]  w_rot;
    logic [31:0]  w_sub;
    logic [31:0]  w_t;
    logic [31:0]  w_w4;
    logic [31:0]  w_w5;
    logic [31:0]  w_w6;
    logic [31:0]  w_w7;
    logic [127:0] w_next_rk;

    assign w_round_inc = r_round + 4'd1;
    assign w_rot       = {r_rk[23:0], r_rk[31:24]};

    generate
        for (genvar g = 0; g < 4; g++) begin : g_sbox
            aes_sbox u_sbox (
                .i_byte (w_rot[8*g +: 8]),
                .o_byte (w_sub[8*g +: 8])
            );
        end
    endgenerate

    // Each new word chains off the one before it, giving the 4-deep xor path.
    assign w_t       = w_sub ^ {rcon_lookup(w_round_inc), 24'h000000};
    assign w_w4      = r_rk[127:96] ^ w_t;
    assign w_w5      = r_rk[95:64]  ^ w_w4;
    assign w_w6      = r_rk[63:32]  ^ w_w5;
    assign w_w7      = r_rk[31:0]   ^ w_w6;
    assign w_next_rk = {w_w4, w_w5, w_w6, w_w7};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_key_ready <= 1'b1;
            r_rk_valid  <= 1'b0;
            r_rk        <= 128'h0;
            r_round     <= 4'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (key_valid) begin
                        r_state     <= c_st_stream;
                        r_key_ready <= 1'b0;
                        r_rk_valid  <= 1'b1;
                        r_rk        <= key;
                        r_round     <= 4'd0;
                    end
                end
                c_st_stream: begin
                    if (rk_ready) begin
                        if (r_round == c_nr) begin
                            r_state     <= c_st_idle;
                            r_key_ready <= 1'b1;
                            r_rk_valid  <= 1'b0;
                        end else begin
                            r_rk    <= w_next_rk;
                            r_round <= w_round_inc;
                        end
                    end
                end
                default: begin
                    r_state     <= c_st_idle;
                    r_key_ready <= 1'b1;
                    r_rk_valid  <= 1'b0;
                end
            endcase
        end
    end

    assign key_ready = r_key_ready;
    assign rk_valid  = r_rk_valid;
    assign rk        = r_rk;
    assign rk_round  = r_round;
    assign rk_last   = r_rk_valid && (r_round == c_nr);

endmodule
`default_nettype wire

// File: tb/tb_aes_key_expand.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_key_expand
// Description : Scoreboard bench for aes_key_expand against a FIPS-197 model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_key_expand;

    typedef struct {
        logic [3:0]   round;
        logic [127:0] rk;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         key_valid;
    logic [127:0] key;
    logic         key_ready;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk;
    logic [3:0]   rk_round;
    logic         rk_last;

    int           checks;
    int           failures;
    int           bp_mode;
    exp_t         sb[$];
    logic [127:0] got[11];
    logic [127:0] ref_rk[11];
    logic [127:0] saved[11];
    logic [7:0]   model_sbox[256];

    aes_key_expand dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key       (key),
        .key_ready (key_ready),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk        (rk),
        .rk_round  (rk_round),
        .rk_last   (rk_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv, s;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            model_sbox[x] = s;
        end
    endtask

    task automatic model_expand(input logic [127:0] k);
        logic [31:0] w[44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {model_sbox[tmp[31:24]], model_sbox[tmp[23:16]],
                       model_sbox[tmp[15:8]], model_sbox[tmp[7:0]]} ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // rk_ready: held high, or randomly toggled when backpressure is on.
    always @(posedge clk) begin
        #1;
        rk_ready = (bp_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: pops the scoreboard on each accepted beat, checks stall stability.
    logic         prev_stall;
    logic [127:0] prev_rk;
    logic [3:0]   prev_round;
    initial prev_stall = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_rk", rk, prev_rk);
                chk("stall_round", 128'(rk_round), 128'(prev_round));
                chk("stall_valid", 128'(rk_valid), 128'(1));
            end
            if (rk_valid && rk_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 128'(rk_round), 128'hx);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_round", 128'(rk_round), 128'(e.round));
                    chk("sb_rk", rk, e.rk);
                    chk("sb_last", 128'(rk_last), 128'(e.round == 4'd10));
                    if (rk_round <= 4'd10) got[rk_round] = rk;
                end
            end
            prev_stall = rk_valid && !rk_ready;
            prev_rk    = rk;
            prev_round = rk_round;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the round-0 beat is presented.
    task automatic send_key(input logic [127:0] k);
        int n;
        n = 0;
        key       = k;
        key_valid = 1'b1;
        while (!key_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!key_ready) begin
            chk("key_ready_timeout", 128'(key_ready), 128'(1));
            key_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_expand(k);
        for (int r = 0; r < 11; r++) sb.push_back('{round: 4'(r), rk: ref_rk[r]});
        #1;
        key_valid = 1'b0;
        key       = {$urandom, $urandom, $urandom, $urandom};
        chk("lat_valid", 128'(rk_valid), 128'(1));
        chk("lat_round0", 128'(rk_round), 128'(0));
        chk("lat_busy", 128'(key_ready), 128'(0));
    endtask

    task automatic wait_end(output int len);
        int n;
        len = 0;
        n   = 0;
        do begin
            @(negedge clk);
            if (rk_valid) len++;
            n++;
        end while (!(rk_valid && rk_last && rk_ready) && n < 400);
        if (n >= 400) begin
            chk("stream_timeout", 128'(n), 128'(0));
            return;
        end
        @(posedge clk); #1;
        chk("ready_back", 128'(key_ready), 128'(1));
        chk("valid_drop", 128'(rk_valid), 128'(0));
    endtask

    localparam logic [127:0] c_fips_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    initial begin
        int len;
        int n;
        checks    = 0;
        failures  = 0;
        bp_mode   = 0;
        rst       = 1'b1;
        key_valid = 1'b0;
        key       = 128'h0;
        rk_ready  = 1'b1;
        build_sbox();
        chk("model_sbox_00", 128'(model_sbox[0]), 128'h63);
        chk("model_sbox_53", 128'(model_sbox[8'h53]), 128'hed);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_key_ready", 128'(key_ready), 128'(1));
        chk("rst_rk_valid", 128'(rk_valid), 128'(0));
        chk("rst_rk_last", 128'(rk_last), 128'(0));
        chk("rst_rk", rk, 128'h0);
        chk("rst_rk_round", 128'(rk_round), 128'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // FIPS-197 vector with no backpressure.
        send_key(c_fips_key);
        wait_end(len);
        chk("stream_len", 128'(len), 128'(11));
        chk("fips_r0", got[0], c_fips_key);
        chk("fips_r1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("fips_r10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        for (int r = 0; r < 11; r++) saved[r] = got[r];

        // Same key under random backpressure.
        bp_mode = 1;
        send_key(c_fips_key);
        wait_end(len);
        for (int r = 0; r < 11; r++) chk("bp_same_keys", got[r], saved[r]);
        bp_mode = 0;

        send_key(128'h000102030405060708090a0b0c0d0e0f);
        wait_end(len);
        chk("seq_r10", got[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

        // Key offered mid-stream must wait for key_ready.
        bp_mode = 1;
        send_key(c_fips_key);
        repeat (3) @(posedge clk);
        #1;
        key       = 128'hdeadbeef_01234567_89abcdef_cafef00d;
        key_valid = 1'b1;
        chk("busy_key_ready", 128'(key_ready), 128'(0));
        wait_end(len);
        chk("busy_r10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        send_key(128'hdeadbeef_01234567_89abcdef_cafef00d);
        wait_end(len);
        bp_mode = 0;

        // Reset at round 5.
        send_key({$urandom, $urandom, $urandom, $urandom});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(rk_valid && rk_round == 4'd5) && n < 100);
        chk("reach_round5", 128'(rk_round), 128'(5));
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_valid", 128'(rk_valid), 128'(0));
        chk("mid_rst_ready", 128'(key_ready), 128'(1));
        chk("mid_rst_rk", rk, 128'h0);
        chk("mid_rst_round", 128'(rk_round), 128'(0));
        send_key(c_fips_key);
        wait_end(len);

        // Back-to-back random keys, mixed backpressure.
        for (int i = 0; i < 6; i++) begin
            bp_mode = i % 2;
            send_key({$urandom, $urandom, $urandom, $urandom});
            wait_end(len);
        end

        repeat (3) @(posedge clk);
        chk("sb_drained", 128'(sb.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/aes_key_expand.md
# aes_key_expand

Iterative AES-128 key schedule that sits directly upstream of `AES_cipher`. It accepts one 128-bit cipher key per handshake and streams the 11 round keys (rounds 0..10) one per accepted beat with valid/ready flow control. Each round key is derived from the previous one in a single cycle. The cipher core or a round-key buffer consumes the stream.

## Interface
Parameters:
- none; the block is fixed to AES-128 (Nk=4, Nr=10).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `key_valid`  in  1  `key` is valid this cycle.
- `key`  in  128  cipher key; word w0 = `key[127:96]`, w3 = `key[31:0]`.
- `key_ready`  out  1  block is idle and will accept a key.
- `rk_valid`  out  1  `rk` / `rk_round` hold a valid round key.
- `rk_ready`  in  1  consumer accepts the current round key.
- `rk`  out  128  round key, same word ordering as `key`.
- `rk_round`  out  4  round index of `rk`, 0..10.
- `rk_last`  out  1  high exactly when `rk_valid` is high and `rk_round` == 10.

## Operation
- FSM states:
  - IDLE: `key_ready`=1, `rk_valid`=0.
  - STREAM: `key_ready`=0, `rk_valid`=1.
- IDLE → STREAM on `key_valid & key_ready`:
  - Register `rk` ← `key`, `rk_round` ← 0.
  - `rk_valid` = 1 and `key_ready` = 0 from the next cycle.
- In STREAM, on `rk_valid & rk_ready` with `rk_round` < 10:
  - `rk` ← next(`rk`, `rk_round`+1).
  - `rk_round` ← `rk_round`+1.
- In STREAM, on `rk_valid & rk_ready` with `rk_round` == 10 → IDLE:
  - `rk_valid` ← 0, `key_ready` ← 1.
  - `rk` and `rk_round` hold their last values.
- In STREAM with `rk_ready` = 0: `rk`, `rk_round` and `rk_valid` hold unchanged. No dropped or skipped rounds.
- next(prev, r):
  - t = SubWord(RotWord(w3)) xor {RCON[r], 24'h0}
  - w4 = w0^t, w5 = w1^w4, w6 = w2^w5, w7 = w3^w6
  - RotWord({a,b,c,d}) = {b,c,d,a}
  - SubWord applies the AES S-box to each byte.
- RCON[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- `key_valid` is ignored outside IDLE; a key offered during STREAM is not captured.
- `key` is sampled only on the accepting edge. Later changes to `key` do not affect the stream in progress.

## Timing
- Reset values (first edge with `rst`=1):
  - state IDLE, `key_ready`=1, `rk_valid`=0, `rk_last`=0.
  - `rk`=128'h0, `rk_round`=0.
- `rst` overrides everything, including a handshake on the same edge. Mid-stream reset aborts the stream and returns to IDLE; no further round keys are produced.
- Latency from key accept to round 0 valid: 1 cycle. Each subsequent round key is valid 1 cycle after the previous one is accepted.
- Minimum stream length with `rk_ready` held at 1:
  - 11 cycles of `rk_valid`.
  - `key_ready` returns the cycle after the round-10 accept.
  - Key-to-key throughput: 12 cycles.
- All outputs are registered, except `rk_last`, which is decoded from registered `rk_valid` and `rk_round`. No combinational path from inputs to outputs.
- Critical path: S-box lookup plus a 4-deep xor chain.

## Structure
- The shared AES include/package holds:
  - the 256-entry S-box table;
  - the RCON table indexed 1..10;
  - the constant NR = 10.
- Sub-module `aes_sbox`: combinational 8-bit in / 8-bit out lookup, instantiated 4 times for SubWord. The cipher core's SubBytes reuses the same module.
- The FSM, the round counter and the next-key datapath live in `aes_key_expand`.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c with `rk_ready`=1:
  - round 0 = the key;
  - round 1 = a0fafe1788542cb123a339392a6c7605;
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6, with `rk_last`=1;
  - `key_ready`=1 on the following cycle.
- Backpressure: same key, toggle `rk_ready` pseudo-randomly.
  - `rk` and `rk_round` stay stable while stalled.
  - The 11 round keys are identical to the unstalled run.
- Key 000102030405060708090a0b0c0d0e0f: round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
- During STREAM, drive `key_valid`=1 with a different key:
  - the stream is unaffected;
  - the new key is accepted only once `key_ready` returns.
- Assert `rst` for one cycle at round 5:
  - next cycle `rk_valid`=0, `key_ready`=1, `rk`=0, `rk_round`=0;
  - a new key is then accepted and its round 0 appears 1 cycle later.
- Back-to-back: a second key offered on the cycle `key_ready` rises is accepted immediately, and its round 0 appears 1 cycle later.
